wb_regfile: RTL and testbench

Writeback-side sink of the MEM/WB pipeline register: consumes the registered `wb_*` bundle and commits it to architectural state. It holds the 32×32 general-purpose register file and the HI/LO pair. It serves two ID-stage read ports and one HI/LO read port, each with write-through bypass, so a value written in WB is visible to a reader in the same cycle. It also keeps a retired-write counter for debug.

---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/wb_regfile_if.sv | 34 +++
 rtl/wb_regfile_hilo_reg.sv | 48 ++++
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file: enable/reset polarities,
// the hardwired-zero register index and the GPR commit rule.
package wb_regfile_pkg;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam int   REG_ZERO      = 0;

    // A GPR write only retires when enabled and not aimed at the zero register.
    function automatic logic gpr_commit(input logic wreg, input logic wd_is_zero);
        return (wreg == WRITE_ENABLE) && !wd_is_zero;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bundle plus the ID-stage read ports and debug counter.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic [CNT_W-1:0]  wb_cnt;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, wb_cnt
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o, wb_cnt
    );
endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO storage with asynchronous active-low reset and same-cycle write bypass.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_i == WRITE_ENABLE) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Reset must force zero even while a write is being presented.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst != RST_ENABLE) begin
            hi_o = hi_d;
            lo_o = lo_d;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 GPRs with r0 hardwired zero, two bypassed
// read ports, HI/LO pair and a retired-GPR-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);

    logic [DATA_W-1:0] gpr_q [REG_NUM];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gpr_we;

    assign gpr_we = gpr_commit(bus.wb_wreg, bus.wb_wd == ADDR_W'(REG_ZERO));

    always_comb begin
        cnt_d = cnt_q;
        if (gpr_we) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (gpr_we) begin
                gpr_q[bus.wb_wd] <= bus.wb_wdata;
            end
            cnt_q <= cnt_d;
        end
    end

    // Priority: reset, zero register, disabled port, WB bypass, stored value.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic              rst_l,
        input logic              re,
        input logic [ADDR_W-1:0] ra,
        input logic              wreg,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (rst_l == RST_ENABLE)            return '0;
        if (ra == ADDR_W'(REG_ZERO))        return '0;
        if (re != READ_ENABLE)              return '0;
        if (wreg == WRITE_ENABLE && wd == ra) return wdata;
        return stored;
    endfunction

    always_comb begin
        bus.rdata1 = rd_sel(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                            bus.wb_wdata, gpr_q[bus.raddr1]);
        bus.rdata2 = rd_sel(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                            bus.wb_wdata, gpr_q[bus.raddr2]);
    end

    assign bus.wb_cnt = cnt_q;

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we_i (bus.wb_whilo),
        .hi_i (bus.wb_hi),
        .lo_i (bus.wb_lo),
        .hi_o (bus.hi_o),
        .lo_o (bus.lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed writeback scenarios followed by
// randomized traffic against an array-based architectural model.
module tb_wb_regfile;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] m_read(input logic r, input logic re, input logic [4:0] a,
                                           input logic wreg, input logic [4:0] wd,
                                           input logic [31:0] wdata);
        if (!r || a == 5'd0 || !re) return 32'h0;
        if (wreg && wd == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_cnt = 32'h0;
    endtask

    // Drives one cycle of WB/read inputs between edges, queues the expected
    // outputs, then advances the model to the state after the next edge.
    task automatic apply(input logic r, input logic wreg, input logic [4:0] wd,
                         input logic [31:0] wdata, input logic whilo,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bus.wb_wreg  = wreg;
        bus.wb_wd    = wd;
        bus.wb_wdata = wdata;
        bus.wb_whilo = whilo;
        bus.wb_hi    = h;
        bus.wb_lo    = l;
        bus.re1      = e1;
        bus.raddr1   = a1;
        bus.re2      = e2;
        bus.raddr2   = a2;
        if (!r) m_clear();
        e.r1  = m_read(r, e1, a1, wreg, wd, wdata);
        e.r2  = m_read(r, e2, a2, wreg, wd, wdata);
        e.hi  = !r ? 32'h0 : (whilo ? h : m_hi);
        e.lo  = !r ? 32'h0 : (whilo ? l : m_lo);
        e.cnt = m_cnt;
        sb.push_back(e);
        if (r) begin
            if (wreg && wd != 5'd0) begin
                m_regs[wd] = wdata;
                m_cnt = m_cnt + 32'd1;
            end
            if (whilo) begin
                m_hi = h;
                m_lo = l;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                chk("rdata1", bus.rdata1, e.r1);
                chk("rdata2", bus.rdata2, e.r2);
                chk("hi_o",   bus.hi_o,   e.hi);
                chk("lo_o",   bus.lo_o,   e.lo);
                chk("wb_cnt", bus.wb_cnt, e.cnt);
            end
        end
    end

    initial begin : stim
        m_clear();
        bus.wb_wreg = 1'b0; bus.wb_wd = '0; bus.wb_wdata = '0;
        bus.wb_whilo = 1'b0; bus.wb_hi = '0; bus.wb_lo = '0;
        bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;

        // Reset held: writes presented must be ignored, all outputs zero.
        apply(0, 1, 5'd5, 32'h1111_2222, 1, 32'h3, 32'h4, 1, 5'd5, 1, 5'd5);
        apply(1, 1, 5'd5, 32'h1234_5678, 0, 32'h0, 32'h0, 1, 5'd5, 0, 5'd0);
        apply(1, 0, 5'd0, 32'h0,         0, 32'h0, 32'h0, 1, 5'd5, 1, 5'd5);
        apply(1, 1, 5'd7, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 1, 5'd7, 1, 5'd7);
        apply(1, 1, 5'd0, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 1, 5'd0, 1, 5'd7);
        apply(1, 0, 5'd0, 32'h0,         0, 32'h0, 32'h0, 1, 5'd0, 0, 5'd5);
        apply(1, 0, 5'd0, 32'h0,         1, 32'hAAAA_0001, 32'h5555_0002, 1, 5'd7, 0, 5'd5);
        apply(1, 0, 5'd0, 32'h0,         0, 32'h0, 32'h0, 1, 5'd5, 1, 5'd7);
        // Reset asserted between edges while a write is presented.
        apply(0, 1, 5'd9, 32'h0BAD_F00D, 1, 32'h1, 32'h2, 1, 5'd5, 1, 5'd7);
        apply(1, 0, 5'd0, 32'h0,         0, 32'h0, 32'h0, 1, 5'd5, 1, 5'd7);
        apply(1, 1, 5'd3, 32'hCAFE_0003, 1, 32'h10, 32'h20, 1, 5'd3, 1, 5'd9);
        apply(1, 0, 5'd0, 32'h0,         0, 32'h0, 32'h0, 1, 5'd3, 1, 5'd3);

        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 39) != 0,
                  $urandom_range(0, 2) != 0,
                  5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 3) == 0,
                  $urandom, $urandom,
                  $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
